// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: front end for a single-port SRAM wrapper.
// After reset an optional sweep writes zero to every word. Afterwards the
// controller arbitrates one read or one write per cycle with writes winning,
// except that a read blocked for STARVE_MAX consecutive cycles is forced
// through. Read data arrives one cycle after the address; if the consumer
// stalls, the word is parked in a hold register so the SRAM read port stays free.
module sram_access_ctrl #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 80,
    parameter int MASK_W         = 4,
    parameter int STARVE_MAX     = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_rreq_valid,
    output logic              io_rreq_ready,
    input  logic [ADDR_W-1:0] io_rreq_addr,
    output logic              io_rresp_valid,
    input  logic              io_rresp_ready,
    output logic [DATA_W-1:0] io_rresp_data,
    input  logic              io_wreq_valid,
    output logic              io_wreq_ready,
    input  logic [ADDR_W-1:0] io_wreq_addr,
    input  logic [DATA_W-1:0] io_wreq_data,
    input  logic [MASK_W-1:0] io_wreq_mask,
    output logic              io_init_done,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data,
    output logic [MASK_W-1:0] sram_w_mask
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              resp_valid;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic              init_done;
    logic              run;
    logic              forced;
    logic              write_fire;
    logic              read_fire;
    logic              slot_free;

    // State register: reset chooses between the zero sweep and normal operation
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR after the last address has been written
    always_comb begin
        state_next = state;
        if (state == CLEAR && sweep_cnt == LAST_ADDR) begin
            state_next = RUN;
        end
    end

    // Outputs and arbitration; everything is held quiet while reset is high
    always_comb begin
        run            = (state == RUN) && !reset;
        forced         = run && io_rreq_valid && (starve_cnt == STARVE_LIM);
        io_wreq_ready  = run && !forced;
        write_fire     = io_wreq_valid && io_wreq_ready;
        slot_free      = !resp_valid || io_rresp_ready;
        io_rreq_ready  = run && !write_fire && slot_free;
        read_fire      = io_rreq_valid && io_rreq_ready;
        io_rresp_valid = resp_valid && !reset;
        io_rresp_data  = hold_valid ? hold_data : sram_r_data;
        io_init_done   = init_done;
        sram_r_addr    = io_rreq_addr;
        sram_w_en      = 1'b0;
        sram_w_addr    = '0;
        sram_w_data    = '0;
        sram_w_mask    = '0;
        if (!reset && state == CLEAR) begin
            sram_w_en   = 1'b1;
            sram_w_addr = sweep_cnt;
            sram_w_mask = '1;
        end else if (write_fire) begin
            sram_w_en   = 1'b1;
            sram_w_addr = io_wreq_addr;
            sram_w_data = io_wreq_data;
            sram_w_mask = io_wreq_mask;
        end
    end

    // Sweep counter, init flag, starvation counter and response tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            sweep_cnt  <= '0;
            init_done  <= 1'b0;
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
            end
            init_done <= (state_next == RUN);

            if (read_fire || !io_rreq_valid) begin
                starve_cnt <= '0;
            end else if (write_fire) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (read_fire) begin
                resp_valid <= 1'b1;
            end else if (io_rresp_ready) begin
                resp_valid <= 1'b0;
            end

            // The SRAM only presents the word for one cycle; park it on a stall
            if (resp_valid && io_rresp_ready) begin
                hold_valid <= 1'b0;
            end else if (resp_valid && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= sram_r_data;
            end
        end
    end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, SRAM word address width (128 entries).
REQ-002 SHALL have parameter DATA_W, default 80, SRAM word width.
REQ-003 SHALL have parameter MASK_W, default 4, write-mask width.
REQ-004 SHALL have parameter STARVE_MAX, default 3, number of consecutive read-blocked cycles tolerated before the read is forced.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 enables the post-reset zero sweep.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 io_rreq_valid / io_rreq_ready / io_rreq_addr  in/out/in  1/1/ADDR_W  read-request handshake.
REQ-009 io_rresp_valid / io_rresp_ready / io_rresp_data  out/in/out  1/1/DATA_W  read-response handshake.
REQ-010 io_wreq_valid / io_wreq_ready  in/out  1/1  write-request handshake.
REQ-011 io_wreq_addr / io_wreq_data / io_wreq_mask  in  ADDR_W/DATA_W/MASK_W  write payload.
REQ-012 io_init_done  output  1  high once the clear sweep has finished.
REQ-013 sram_r_addr  output  ADDR_W  read address to the single-port SRAM wrapper.
REQ-014 sram_r_data  input  DATA_W  SRAM read data, valid exactly one cycle after the address is presented.
REQ-015 sram_w_en / sram_w_addr / sram_w_data / sram_w_mask  output  1/ADDR_W/DATA_W/MASK_W  SRAM write port; sram_w_en=1 overrides any read that cycle.

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-017 CLEAR SHALL assert sram_w_en=1, sram_w_addr=sweep counter (0 up to 2^ADDR_W-1), sram_w_data=0, sram_w_mask=all ones, one entry per cycle.
REQ-018 CLEAR SHALL hold io_rreq_ready=0 and io_wreq_ready=0.
REQ-019 After the write to the last address, the FSM SHALL move to RUN; io_init_done SHALL be 1 from the next cycle onward.
REQ-020 In RUN, at most one SRAM operation SHALL be issued per cycle.
REQ-021 A write fires when io_wreq_valid&&io_wreq_ready.
REQ-022 A read fires when io_rreq_valid&&io_rreq_ready.
REQ-023 Writes SHALL have priority; io_wreq_ready=1 in RUN unless a read is forced (REQ-024).
REQ-024 Starvation counter SHALL increment each cycle io_rreq_valid=1 and a write fires; when counter==STARVE_MAX, the read SHALL be forced that cycle (io_wreq_ready=0).
REQ-025 The starvation counter SHALL clear on any read fire or when io_rreq_valid=0.
REQ-026 io_rreq_ready = RUN && no write firing (or read forced) && response slot free.
REQ-027 Response slot free = no response pending, or the pending response is accepted this cycle.
REQ-028 A write fire SHALL drive sram_w_en=1 with the request payload; otherwise sram_w_en=0.
REQ-029 A read fire SHALL drive sram_r_addr=io_rreq_addr.
REQ-030 A read fired in cycle T SHALL give io_rresp_valid=1 in T+1 with io_rresp_data=sram_r_data.
REQ-031 If the response is not accepted in T+1, sram_r_data SHALL be captured into a hold register; io_rresp_data SHALL come from that register, stable, until io_rresp_ready=1.
REQ-032 A read issued the cycle after a write to the same address SHALL return the written data (no bypass needed).
REQ-033 Back-to-back reads SHALL sustain one read per cycle while io_rresp_ready=1.

Reset
REQ-034 Reset SHALL force: io_rresp_valid=0, io_init_done=0, sram_w_en=0 in the reset cycle, starvation counter=0, sweep counter=0, hold register valid=0.
REQ-035 Reset asserted mid-sweep or mid-read SHALL discard the in-flight response and restart the sweep from address 0.

Verification
REQ-036 Reset then idle -> sram_w_en=1 for exactly 128 cycles, addr 0..127, data 0, mask 0xF; io_init_done=1 from cycle 129.
REQ-037 Write addr 5 data 0x1234 mask 0xF, then read addr 5 -> io_rresp_valid one cycle after the read fire, data 0x1234.
REQ-038 rreq and wreq both valid continuously -> write accepted 3 cycles, read forced on the 4th, pattern repeats.
REQ-039 Read fires with io_rresp_ready=0 for 5 cycles while the SRAM address changes -> data stable, io_rreq_ready=0 until accepted.
REQ-040 Streaming reads of addr 0..9 with io_rresp_ready=1 -> 10 consecutive responses, one per cycle, in order.
REQ-041 Reset asserted at sweep address 60 -> sweep restarts at 0, no io_rresp_valid, io_init_done=0 until the new sweep completes.
